// File: rtl/tawas_thread_sched_pkg.sv
// Shared types for the Tawas barrel-core thread scheduler.
package tawas_pkg;

    localparam int TAWAS_NTHREADS = 32;
    localparam int TAWAS_TID_W    = 5;

    typedef logic [TAWAS_TID_W-1:0]    tawas_tid_t;
    typedef logic [TAWAS_NTHREADS-1:0] tawas_mask_t;

    function automatic tawas_mask_t tawas_onehot(input tawas_tid_t tid);
        return tawas_mask_t'(1) << tid;
    endfunction

endpackage

// File: rtl/tawas_thread_sched_if.sv
// Pipeline-facing signal bundle of the thread scheduler.
interface tawas_thread_sched_if;
    import tawas_pkg::*;

    tawas_mask_t thread_en;
    logic        ld_issue;
    tawas_tid_t  ld_issue_thread;
    logic        rcn_load_en;
    tawas_tid_t  rcn_load_thread;
    logic        err_clr;
    logic        thread_load_en;
    tawas_tid_t  thread_load;
    logic        sched_idle;
    tawas_mask_t pend_busy;
    logic        err_overflow;
    logic        err_underflow;

    modport master (
        output thread_en, ld_issue, ld_issue_thread, rcn_load_en, rcn_load_thread, err_clr,
        input  thread_load_en, thread_load, sched_idle, pend_busy, err_overflow, err_underflow
    );

    modport slave (
        input  thread_en, ld_issue, ld_issue_thread, rcn_load_en, rcn_load_thread, err_clr,
        output thread_load_en, thread_load, sched_idle, pend_busy, err_overflow, err_underflow
    );

endinterface

// File: rtl/tawas_thread_sched_rr_pick.sv
// Rotate-priority find-first: lowest set request at or after start, wrapping 31 -> 0.
module tawas_rr_pick
    import tawas_pkg::*;
(
    input  tawas_mask_t req,
    input  tawas_tid_t  start,
    output logic        found,
    output tawas_tid_t  idx
);

    tawas_tid_t cand;

    // Scan from the far end so the nearest candidate is the last write.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = start;
        for (int k = TAWAS_NTHREADS - 1; k >= 0; k--) begin
            cand = start + tawas_tid_t'(k);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/tawas_thread_sched.sv
// Round-robin thread picker with per-thread load tracking and re-issue spacing.
module tawas_thread_sched
    import tawas_pkg::*;
#(
    parameter int PIPE_DEPTH = 4,
    parameter int MAX_PEND   = 3,
    parameter int RET_DELAY  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tawas_thread_sched_if.slave  bus
);

    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int HD = PIPE_DEPTH - 1;

    typedef logic [PW-1:0] pend_t;
    localparam pend_t PEND_MAX = pend_t'(MAX_PEND);

    pend_t            pend     [TAWAS_NTHREADS];
    pend_t            pend_nxt [TAWAS_NTHREADS];
    logic             ovf, unf;

    logic [RET_DELAY-1:0] ret_v;
    tawas_tid_t       ret_id [RET_DELAY];
    logic             ret_eff;
    tawas_tid_t       ret_eff_id;

    logic [HD-1:0]    hist_v;
    tawas_tid_t       hist_id [HD];

    tawas_tid_t       last;
    tawas_tid_t       start;
    tawas_mask_t      busy, recent, issue_mask, eligible;
    logic             pick_found;
    tawas_tid_t       pick_idx;

    logic             load_en_q, idle_q, err_ovf_q, err_unf_q;
    tawas_tid_t       load_q;

    assign ret_eff    = ret_v[RET_DELAY-1];
    assign ret_eff_id = ret_id[RET_DELAY-1];

    always_comb begin
        pend_nxt = pend;
        ovf      = 1'b0;
        unf      = 1'b0;
        for (int i = 0; i < TAWAS_NTHREADS; i++) begin
            if (bus.ld_issue && bus.ld_issue_thread == tawas_tid_t'(i) &&
                !(ret_eff && ret_eff_id == tawas_tid_t'(i))) begin
                if (pend[i] == PEND_MAX) ovf = 1'b1;
                else                     pend_nxt[i] = pend[i] + 1'b1;
            end else if (ret_eff && ret_eff_id == tawas_tid_t'(i) &&
                         !(bus.ld_issue && bus.ld_issue_thread == tawas_tid_t'(i))) begin
                if (pend[i] == '0) unf = 1'b1;
                else               pend_nxt[i] = pend[i] - 1'b1;
            end
        end
    end

    always_comb begin
        busy   = '0;
        recent = '0;
        for (int i = 0; i < TAWAS_NTHREADS; i++) busy[i] = (pend[i] != '0);
        for (int k = 0; k < HD; k++) if (hist_v[k]) recent[hist_id[k]] = 1'b1;
    end

    // A thread issuing a load this cycle must not be handed out on the next output.
    assign issue_mask = bus.ld_issue ? tawas_onehot(bus.ld_issue_thread) : '0;
    assign eligible   = bus.thread_en & ~busy & ~recent & ~issue_mask;
    assign start      = last + 1'b1;

    tawas_rr_pick u_pick (
        .req   (eligible),
        .start (start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_en_q <= 1'b0;
            load_q    <= '0;
            idle_q    <= 1'b0;
            last      <= '1;
            hist_v    <= '0;
            ret_v     <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            for (int i = 0; i < TAWAS_NTHREADS; i++) pend[i] <= '0;
        end else begin
            load_en_q <= pick_found;
            idle_q    <= !pick_found;
            if (pick_found) begin
                load_q <= pick_idx;
                last   <= pick_idx;
            end
            hist_v[0] <= pick_found;
            for (int k = 1; k < HD; k++) hist_v[k] <= hist_v[k-1];
            ret_v[0] <= bus.rcn_load_en;
            for (int k = 1; k < RET_DELAY; k++) ret_v[k] <= ret_v[k-1];
            err_ovf_q <= ovf | (err_ovf_q & ~bus.err_clr);
            err_unf_q <= unf | (err_unf_q & ~bus.err_clr);
            pend      <= pend_nxt;
        end
    end

    // Thread ids ride alongside their valid bits and need no reset.
    always_ff @(posedge clk) begin
        hist_id[0] <= pick_idx;
        for (int k = 1; k < HD; k++) hist_id[k] <= hist_id[k-1];
        ret_id[0] <= bus.rcn_load_thread;
        for (int k = 1; k < RET_DELAY; k++) ret_id[k] <= ret_id[k-1];
    end

    assign bus.thread_load_en = load_en_q;
    assign bus.thread_load    = load_q;
    assign bus.sched_idle     = idle_q;
    assign bus.pend_busy      = busy;
    assign bus.err_overflow   = err_ovf_q;
    assign bus.err_underflow  = err_unf_q;

endmodule

// File: tb/tb_tawas_thread_sched.sv
// Directed bench for tawas_thread_sched with default parameters (4/3/3).
module tb_tawas_thread_sched;
    import tawas_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    tawas_thread_sched_if bus();

    tawas_thread_sched #(.PIPE_DEPTH(4), .MAX_PEND(3), .RET_DELAY(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus.thread_en = '0;
        bus.ld_issue = 1'b0;
        bus.ld_issue_thread = '0;
        bus.rcn_load_en = 1'b0;
        bus.rcn_load_thread = '0;
        bus.err_clr = 1'b0;
        repeat (3) tick();
        checks++; if (bus.thread_load_en !== 1'b0) begin errors++; $display("FAIL reset_load_en: got %b expected 0", bus.thread_load_en); end
        checks++; if (bus.thread_load !== 5'd0) begin errors++; $display("FAIL reset_load: got %0d expected 0", bus.thread_load); end
        checks++; if (bus.sched_idle !== 1'b0) begin errors++; $display("FAIL reset_idle: got %b expected 0", bus.sched_idle); end
        checks++; if (bus.pend_busy !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", bus.pend_busy); end
        checks++; if ({bus.err_overflow, bus.err_underflow} !== 2'b00) begin errors++; $display("FAIL reset_err: got %b expected 00", {bus.err_overflow, bus.err_underflow}); end
        rst_n = 1'b1;
    endtask

    task automatic test_round_robin;
        bus.thread_en = 32'hFFFF_FFFF;
        for (int k = 0; k <= 32; k++) begin
            tick();
            checks++;
            if (bus.thread_load_en !== 1'b1 || bus.thread_load !== 5'(k % 32)) begin
                errors++;
                $display("FAIL rr_pick %0d: got en=%b tid=%0d expected en=1 tid=%0d", k, bus.thread_load_en, bus.thread_load, k % 32);
            end
        end
    endtask

    task automatic test_pipe_spacing;
        bus.thread_en = 32'h0000_0020;
        tick();
        checks++; if (bus.thread_load_en !== 1'b1 || bus.thread_load !== 5'd5) begin errors++; $display("FAIL space_first: got en=%b tid=%0d expected en=1 tid=5", bus.thread_load_en, bus.thread_load); end
        for (int r = 0; r < 3; r++) begin
            for (int g = 0; g < 3; g++) begin
                tick();
                checks++;
                if (bus.thread_load_en !== 1'b0 || bus.sched_idle !== 1'b1 || bus.thread_load !== 5'd5) begin
                    errors++;
                    $display("FAIL space_gap r%0d g%0d: got en=%b idle=%b tid=%0d expected en=0 idle=1 tid=5", r, g, bus.thread_load_en, bus.sched_idle, bus.thread_load);
                end
            end
            tick();
            checks++;
            if (bus.thread_load_en !== 1'b1 || bus.sched_idle !== 1'b0 || bus.thread_load !== 5'd5) begin
                errors++;
                $display("FAIL space_pick r%0d: got en=%b idle=%b tid=%0d expected en=1 idle=0 tid=5", r, bus.thread_load_en, bus.sched_idle, bus.thread_load);
            end
        end
    endtask

    task automatic test_pending;
        logic exp_en, exp_busy;
        bus.thread_en = 32'h0000_0004;
        bus.ld_issue = 1'b1;
        bus.ld_issue_thread = 5'd2;
        for (int n = 1; n <= 15; n++) begin
            tick();
            exp_en   = (n == 15);
            exp_busy = (n <= 13);
            checks++;
            if (bus.thread_load_en !== exp_en || bus.sched_idle !== !exp_en || bus.pend_busy[2] !== exp_busy) begin
                errors++;
                $display("FAIL pend_cycle %0d: got en=%b idle=%b busy2=%b expected en=%b idle=%b busy2=%b", n, bus.thread_load_en, bus.sched_idle, bus.pend_busy[2], exp_en, !exp_en, exp_busy);
            end
            if (n == 1) bus.ld_issue = 1'b0;
            if (n == 10) begin bus.rcn_load_en = 1'b1; bus.rcn_load_thread = 5'd2; end
            if (n == 11) bus.rcn_load_en = 1'b0;
        end
        checks++; if (bus.thread_load !== 5'd2) begin errors++; $display("FAIL pend_repick: got tid=%0d expected 2", bus.thread_load); end
    endtask

    task automatic test_overflow;
        bus.thread_en = '0;
        bus.ld_issue = 1'b1;
        bus.ld_issue_thread = 5'd7;
        repeat (3) tick();
        checks++; if (bus.err_overflow !== 1'b0 || bus.pend_busy[7] !== 1'b1) begin errors++; $display("FAIL ovf_three: got ovf=%b busy7=%b expected ovf=0 busy7=1", bus.err_overflow, bus.pend_busy[7]); end
        tick();
        bus.ld_issue = 1'b0;
        checks++; if (bus.err_overflow !== 1'b1 || bus.pend_busy[7] !== 1'b1) begin errors++; $display("FAIL ovf_fourth: got ovf=%b busy7=%b expected ovf=1 busy7=1", bus.err_overflow, bus.pend_busy[7]); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.err_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.err_overflow); end
        bus.rcn_load_en = 1'b1;
        bus.rcn_load_thread = 5'd7;
        repeat (3) tick();
        bus.rcn_load_en = 1'b0;
        repeat (2) tick();
        checks++; if (bus.pend_busy[7] !== 1'b1) begin errors++; $display("FAIL ovf_drain_mid: got busy7=%b expected 1", bus.pend_busy[7]); end
        tick();
        checks++; if (bus.pend_busy[7] !== 1'b0 || bus.err_underflow !== 1'b0) begin errors++; $display("FAIL ovf_drain_end: got busy7=%b unf=%b expected busy7=0 unf=0", bus.pend_busy[7], bus.err_underflow); end
    endtask

    task automatic test_underflow;
        bus.rcn_load_en = 1'b1;
        bus.rcn_load_thread = 5'd9;
        tick();
        bus.rcn_load_en = 1'b0;
        repeat (2) tick();
        checks++; if (bus.err_underflow !== 1'b0) begin errors++; $display("FAIL unf_early: got %b expected 0", bus.err_underflow); end
        tick();
        checks++; if (bus.err_underflow !== 1'b1 || bus.pend_busy[9] !== 1'b0) begin errors++; $display("FAIL unf_set: got unf=%b busy9=%b expected unf=1 busy9=0", bus.err_underflow, bus.pend_busy[9]); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.err_underflow !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b expected 0", bus.err_underflow); end
        bus.rcn_load_en = 1'b1;
        tick();
        bus.rcn_load_en = 1'b0;
        repeat (2) tick();
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        checks++; if (bus.err_underflow !== 1'b1) begin errors++; $display("FAIL unf_set_wins_clr: got %b expected 1", bus.err_underflow); end
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
    endtask

    task automatic test_same_cycle;
        bus.ld_issue = 1'b1;
        bus.ld_issue_thread = 5'd4;
        tick();
        bus.ld_issue = 1'b0;
        bus.rcn_load_en = 1'b1;
        bus.rcn_load_thread = 5'd4;
        tick();
        bus.rcn_load_en = 1'b0;
        repeat (2) tick();
        bus.ld_issue = 1'b1;
        tick();
        bus.ld_issue = 1'b0;
        repeat (2) tick();
        checks++; if (bus.pend_busy[4] !== 1'b1 || bus.err_overflow !== 1'b0 || bus.err_underflow !== 1'b0) begin errors++; $display("FAIL same_cycle_net0: got busy4=%b ovf=%b unf=%b expected 1 0 0", bus.pend_busy[4], bus.err_overflow, bus.err_underflow); end
        bus.rcn_load_en = 1'b1;
        tick();
        bus.rcn_load_en = 1'b0;
        repeat (3) tick();
        checks++; if (bus.pend_busy[4] !== 1'b0 || bus.err_underflow !== 1'b0) begin errors++; $display("FAIL same_cycle_drain: got busy4=%b unf=%b expected 0 0", bus.pend_busy[4], bus.err_underflow); end
    endtask

    task automatic test_reset_mid;
        bus.thread_en = '0;
        bus.ld_issue = 1'b1;
        bus.ld_issue_thread = 5'd3;
        bus.rcn_load_en = 1'b1;
        bus.rcn_load_thread = 5'd6;
        tick();
        bus.ld_issue = 1'b0;
        bus.rcn_load_thread = 5'd3;
        tick();
        bus.rcn_load_en = 1'b0;
        checks++; if (bus.pend_busy[3] !== 1'b1 || bus.sched_idle !== 1'b1) begin errors++; $display("FAIL rstmid_pre: got busy3=%b idle=%b expected 1 1", bus.pend_busy[3], bus.sched_idle); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.thread_load_en !== 1'b0 || bus.thread_load !== 5'd0 || bus.sched_idle !== 1'b0 || bus.pend_busy !== 32'h0) begin
            errors++;
            $display("FAIL rstmid_async: got en=%b tid=%0d idle=%b busy=%h expected 0 0 0 0", bus.thread_load_en, bus.thread_load, bus.sched_idle, bus.pend_busy);
        end
        #2;
        rst_n = 1'b1;
        bus.thread_en = 32'hFFFF_FFFF;
        bus.ld_issue = 1'b1;
        bus.ld_issue_thread = 5'd3;
        tick();
        bus.ld_issue = 1'b0;
        checks++; if (bus.thread_load_en !== 1'b1 || bus.thread_load !== 5'd0) begin errors++; $display("FAIL rstmid_first: got en=%b tid=%0d expected en=1 tid=0", bus.thread_load_en, bus.thread_load); end
        for (int n = 0; n < 5; n++) begin
            tick();
            checks++;
            if (bus.pend_busy[3] !== 1'b1 || bus.err_underflow !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_stale %0d: got busy3=%b unf=%b expected 1 0", n, bus.pend_busy[3], bus.err_underflow);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_round_robin();
        test_pipe_spacing();
        test_pending();
        test_overflow();
        test_underflow();
        test_same_cycle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
